mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped LED/switch/key/seven-segment/timer responder with one-cycle registered reads.
// Define MMIO_KEY_DEBOUNCE_EN to build the key debounce counter; otherwise the synchronized key is used directly.
module mmio_responder #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic [23:0] switch_in,
    input  logic        key_in,
    output logic [23:0] led_out,
    output logic [31:0] seg_out
);
    localparam logic [7:0] IDX_LED   = 8'h00;
    localparam logic [7:0] IDX_SW    = 8'h01;
    localparam logic [7:0] IDX_KEY   = 8'h02;
    localparam logic [7:0] IDX_SEG   = 8'h03;
    localparam logic [7:0] IDX_TIMER = 8'h04;

    logic [7:0]  idx_s;
    logic        rd_en_s;
    logic        key_rd_s;
    logic        timer_wr_s;
    logic [31:0] timer_r;
    logic [31:0] timer_nxt_s;
    logic [31:0] rd_mux_s;
    logic [23:0] sw_meta_r;
    logic [23:0] sw_sync_r;
    logic        key_meta_r;
    logic        key_sync_r;
    logic        key_level_s;
    logic        key_level_d_r;
    logic        rise_s;
    logic        flag_r;

    assign idx_s      = addr[9:2];
    assign rd_en_s    = io_read & ~io_write;
    assign key_rd_s   = rd_en_s & (idx_s == IDX_KEY);
    assign timer_wr_s = io_write & (idx_s == IDX_TIMER);
    assign rise_s     = key_level_s & ~key_level_d_r;

    // A TIMER read returns the value the counter holds while rdata is valid, so a load reads back as 1.
    assign timer_nxt_s = timer_wr_s ? 32'd0 : (timer_r + 32'd1);

`ifdef MMIO_KEY_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic             key_prev_r;
    logic             key_level_r;
    logic [CNT_W-1:0] deb_cnt_r;

    // Debounce: accept a new level once it has been stable for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            key_prev_r  <= 1'b0;
            key_level_r <= 1'b0;
            deb_cnt_r   <= '0;
        end else begin
            key_prev_r <= key_sync_r;
            if ((key_sync_r == key_level_r) || (key_sync_r != key_prev_r)) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                key_level_r <= key_sync_r;
                deb_cnt_r   <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign key_level_s = key_level_r;
`else
    assign key_level_s = key_sync_r;
`endif

    // Read data selection; unmapped offsets and unused high bits read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (idx_s)
            IDX_LED:   rd_mux_s = {8'd0, led_out};
            IDX_SW:    rd_mux_s = {8'd0, sw_sync_r};
            IDX_KEY:   rd_mux_s = {31'd0, flag_r};
            IDX_SEG:   rd_mux_s = seg_out;
            IDX_TIMER: rd_mux_s = timer_nxt_s;
            default:   rd_mux_s = 32'd0;
        endcase
    end

    // Synchronizers, key edge detect, pressed flag, timer and write-side registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sw_meta_r     <= 24'd0;
            sw_sync_r     <= 24'd0;
            key_meta_r    <= 1'b0;
            key_sync_r    <= 1'b0;
            key_level_d_r <= 1'b0;
            flag_r        <= 1'b0;
            timer_r       <= 32'd0;
            led_out       <= 24'd0;
            seg_out       <= 32'd0;
        end else begin
            sw_meta_r     <= switch_in;
            sw_sync_r     <= sw_meta_r;
            key_meta_r    <= key_in;
            key_sync_r    <= key_meta_r;
            key_level_d_r <= key_level_s;
            timer_r       <= timer_nxt_s;
            // A new press wins over a clear-on-read in the same cycle.
            if (rise_s) begin
                flag_r <= 1'b1;
            end else if (key_rd_s) begin
                flag_r <= 1'b0;
            end else begin
                flag_r <= flag_r;
            end
            if (io_write && (idx_s == IDX_LED)) begin
                led_out <= wdata[23:0];
            end else begin
                led_out <= led_out;
            end
            if (io_write && (idx_s == IDX_SEG)) begin
                seg_out <= wdata;
            end else begin
                seg_out <= seg_out;
            end
        end
    end

    // Registered read port; rdata holds between reads.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_en_s;
            if (rd_en_s) begin
                rdata <= rd_mux_s;
            end else begin
                rdata <= rdata;
            end
        end
    end
endmodule
